mmio_dbg_master: RTL and testbench

Debug bus master that accepts framed command bytes from a serial byte stream and performs reads/writes on the CPU-side MMIO bus (RAM, UART registers). It sits beside the CPU as a second initiator behind an external request/grant arbiter. It returns one reply byte per accessed location through a byte-stream transmit handshake. It is used for loading RAM images and inspecting memory without CPU involvement.

---
 rtl/mmio_dbg_master_if.sv | 33 +++
 rtl/mmio_dbg_master.sv | 144 ++++++++++++++
 tb/tb_mmio_dbg_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_dbg_master_if.sv
// Byte-stream and MMIO bus bundle for the debug master.
// master: the debug block; slave: host link, arbiter and bus side.
interface mmio_dbg_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        ram_wr;
  logic        ram_oe;
  logic        rx_drop;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  bus_gnt, data_in,
    output tx_data, tx_valid, bus_req,
    output addr_out, data_out,
    output ram_wr, ram_oe, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output bus_gnt, data_in,
    input  tx_data, tx_valid, bus_req,
    input  addr_out, data_out,
    input  ram_wr, ram_oe, rx_drop
  );
endinterface

// File: rtl/mmio_dbg_master.sv
// Serial-framed debug master for the MMIO bus (W/R/D frames).
// Ports: clk_in, reset_in (async high), bus (stream + MMIO master).
module mmio_dbg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned READ_LAT       = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  mmio_dbg_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(READ_LAT + 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, ARG,
    REQ, ACCESS, CAPTURE, SEND
  } state_t;

  state_t      state, state_d;
  logic        op_wr, op_burst;
  logic [15:0] addr;
  logic [7:0]  wdata, reply;
  logic [8:0]  cnt;
  logic [TW-1:0] to_cnt;
  logic [LW-1:0] lat;

  logic tmo, lat_done, bad_cmd, on_bus, more;

  assign tmo      = to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign lat_done = lat == LW'(READ_LAT - 1);
  assign bad_cmd  = !(bus.rx_data == CMD_W ||
                      bus.rx_data == CMD_R ||
                      bus.rx_data == CMD_D);
  assign on_bus   = state == ACCESS || state == CAPTURE;
  assign more     = cnt > 9'd1;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (bus.rx_valid)
          state_d = bad_cmd ? SEND : ADDR_HI;
      ADDR_HI:
        if (bus.rx_valid) state_d = ADDR_LO;
        else if (tmo)     state_d = IDLE;
      ADDR_LO:
        if (bus.rx_valid)
          state_d = (op_wr || op_burst) ? ARG : REQ;
        else if (tmo) state_d = IDLE;
      ARG:
        if (bus.rx_valid) state_d = REQ;
        else if (tmo)     state_d = IDLE;
      REQ:
        if (bus.bus_gnt) state_d = ACCESS;
      ACCESS:
        state_d = op_wr ? SEND : CAPTURE;
      CAPTURE:
        if (lat_done) state_d = SEND;
      SEND:
        if (bus.tx_ready)
          state_d = more ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are zero outside the access window so the
  // CPU can OR its own bus drive onto the same wires.
  assign bus.addr_out = on_bus ? addr : 16'h0000;
  assign bus.data_out = (state == ACCESS && op_wr) ? wdata : 8'h00;
  assign bus.ram_wr   = state == ACCESS && op_wr;
  assign bus.ram_oe   = on_bus && !op_wr;
  assign bus.bus_req  = state == REQ || on_bus;
  assign bus.tx_valid = state == SEND;
  assign bus.tx_data  = (state == SEND) ? reply : 8'h00;
  assign bus.rx_drop  = bus.rx_valid &&
                        (state == REQ || on_bus || state == SEND);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      op_wr    <= 1'b0;
      op_burst <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      reply    <= '0;
      cnt      <= '0;
      to_cnt   <= '0;
      lat      <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.rx_valid) begin
            op_wr    <= bus.rx_data == CMD_W;
            op_burst <= bus.rx_data == CMD_D;
            // cnt=0 makes a NAK reply end the frame
            cnt      <= bad_cmd ? 9'd0 : 9'd1;
            reply    <= NAK;
            wdata    <= '0;
            to_cnt   <= '0;
          end
        ADDR_HI, ADDR_LO, ARG: begin
          if (bus.rx_valid) begin
            to_cnt <= '0;
            if (state == ADDR_HI) addr[15:8] <= bus.rx_data;
            if (state == ADDR_LO) addr[7:0]  <= bus.rx_data;
            if (state == ARG) begin
              if (op_burst)
                cnt <= (bus.rx_data == 8'h00) ? 9'd256
                                              : {1'b0, bus.rx_data};
              else
                wdata <= bus.rx_data;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ACCESS: begin
          lat <= '0;
          if (op_wr) reply <= ACK;
        end
        CAPTURE: begin
          lat <= lat + 1'b1;
          if (lat_done) reply <= bus.data_in;
        end
        SEND:
          if (bus.tx_ready && more) begin
            cnt  <= cnt - 1'b1;
            addr <= addr + 1'b1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_dbg_master.sv
// Directed self-checking bench for mmio_dbg_master.
// Drives frames, models a 1-cycle-latency RAM, checks replies.
module tb_mmio_dbg_master;
  logic clk_in = 1'b0;
  logic reset_in;
  int   checks = 0;
  int   errors = 0;

  mmio_dbg_master_if bus ();

  mmio_dbg_master #(
    .TIMEOUT_CYCLES(16),
    .READ_LAT(1)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  // RAM contents: (lo ^ 08) - hi + 12, chosen so 0x1234 -> 0x3C
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] ^ 8'h08) - a[15:8] + 8'h12;
  endfunction

  always @(posedge clk_in)
    if (reset_in) bus.data_in <= 8'h00;
    else bus.data_in <= bus.ram_oe ? mem_f(bus.addr_out) : 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    sync();
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {bus.tx_valid, bus.bus_req, bus.ram_wr,
                        bus.ram_oe, bus.rx_drop}, 0);
    chk({tag, "_txd"}, bus.tx_data, 0);
    chk({tag, "_adr"}, bus.addr_out, 0);
    chk({tag, "_dat"}, bus.data_out, 0);
  endtask

  // Waits for a reply, recording the first read address seen,
  // then completes the handshake (tx_ready must be high).
  task automatic wait_tx(output logic got,
                         output logic [15:0] a,
                         output logic [7:0] d,
                         output logic req);
    logic seen;
    int n;
    seen = 1'b0;
    a = 16'h0;
    n = 0;
    @(negedge clk_in);
    while (!bus.tx_valid && n < 20) begin
      if (bus.ram_oe && !seen) begin
        seen = 1'b1;
        a = bus.addr_out;
      end
      @(negedge clk_in);
      n++;
    end
    got = bus.tx_valid;
    d = bus.tx_data;
    req = bus.bus_req;
    sync();
  endtask

  task automatic wait_reply(input string tag,
                            input logic [15:0] ea,
                            input logic [7:0] ed);
    logic got, req;
    logic [15:0] a;
    logic [7:0] d;
    wait_tx(got, a, d, req);
    chk({tag, "_got"}, got, 1);
    chk({tag, "_adr"}, a, ea);
    chk({tag, "_dat"}, d, ed);
    chk({tag, "_req"}, req, 0);
  endtask

  initial begin
    logic got, req;
    logic [15:0] a;
    logic [7:0] d;
    int good, bad, drop_seen, drop_extra;

    reset_in = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_ready = 1'b1;
    bus.bus_gnt = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_quiet("rst");
    sync();
    reset_in = 1'b0;
    sync();

    // single write
    send_byte(8'h57); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'hA5);
    @(negedge clk_in);
    chk("wr_n1_req", bus.bus_req, 1);
    chk("wr_n1_wr", bus.ram_wr, 0);
    @(negedge clk_in);
    chk("wr_n2_wr", {bus.ram_wr, bus.ram_oe}, 2'b10);
    chk("wr_n2_adr", bus.addr_out, 16'h1234);
    chk("wr_n2_dat", bus.data_out, 8'hA5);
    @(negedge clk_in);
    chk("wr_n3_wr", bus.ram_wr, 0);
    chk("wr_n3_adr", bus.addr_out, 0);
    chk("wr_n3_tx", {bus.tx_valid, bus.bus_req}, 2'b10);
    chk("wr_n3_txd", bus.tx_data, 8'h06);
    @(negedge clk_in);
    chk("wr_n4_tx", bus.tx_valid, 0);
    sync();

    // single read, ram_oe two cycles wide
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk_in);
    chk("rd_n1", {bus.bus_req, bus.ram_oe}, 2'b10);
    @(negedge clk_in);
    chk("rd_n2_oe", bus.ram_oe, 1);
    chk("rd_n2_adr", bus.addr_out, 16'h1234);
    @(negedge clk_in);
    chk("rd_n3_oe", bus.ram_oe, 1);
    chk("rd_n3_adr", bus.addr_out, 16'h1234);
    chk("rd_n3_tx", bus.tx_valid, 0);
    @(negedge clk_in);
    chk("rd_n4_oe", bus.ram_oe, 0);
    chk("rd_n4_tx", bus.tx_valid, 1);
    chk("rd_n4_txd", bus.tx_data, 8'h3C);
    sync();

    // burst of 3 across the address wrap
    send_byte(8'h44); send_byte(8'hFF);
    send_byte(8'hFE); send_byte(8'h03);
    wait_reply("b3_0", 16'hFFFE, 8'h09);
    wait_reply("b3_1", 16'hFFFF, 8'h0A);
    wait_reply("b3_2", 16'h0000, 8'h1A);
    bad = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (bus.tx_valid || bus.bus_req) bad++;
    end
    chk("b3_end", bad, 0);
    sync();

    // cnt=0 means 256 bytes
    send_byte(8'h44); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00);
    good = 0;
    for (int k = 0; k < 256; k++) begin
      wait_tx(got, a, d, req);
      if (got && !req && a == 16'h0100 + 16'(k) &&
          d == mem_f(16'h0100 + 16'(k)))
        good++;
    end
    chk("b256_cnt", good, 256);
    bad = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (bus.tx_valid || bus.bus_req) bad++;
    end
    chk("b256_end", bad, 0);
    sync();

    // grant withheld for 50 cycles
    bus.bus_gnt = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    bad = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (!bus.bus_req || bus.ram_oe || bus.ram_wr ||
          bus.tx_valid || bus.addr_out != 0) bad++;
    end
    chk("gnt_wait", bad, 0);
    sync();
    bus.bus_gnt = 1'b1;
    @(negedge clk_in);
    chk("gnt_g0", {bus.bus_req, bus.ram_oe}, 2'b10);
    @(negedge clk_in);
    chk("gnt_g1_oe", bus.ram_oe, 1);
    chk("gnt_g1_adr", bus.addr_out, 16'h0010);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("gnt_tx", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h2A});
    sync();

    // timeout mid-frame, then a normal read
    send_byte(8'h57);
    bad = 0;
    repeat (24) begin
      @(negedge clk_in);
      if (bus.bus_req || bus.tx_valid) bad++;
    end
    chk("tmo_quiet", bad, 0);
    sync();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_reply("tmo_rd", 16'h0000, 8'h1A);

    // NAK with tx_ready stalled and a byte dropped
    bus.tx_ready = 1'b0;
    send_byte(8'h99);
    @(negedge clk_in);
    chk("nak_tx", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h15});
    bad = 0;
    drop_seen = 0;
    drop_extra = 0;
    for (int i = 0; i < 10; i++) begin
      sync();
      bus.rx_valid = (i == 4);
      bus.rx_data = 8'h57;
      @(negedge clk_in);
      if (!(bus.tx_valid && bus.tx_data == 8'h15)) bad++;
      if (i == 4) drop_seen = int'(bus.rx_drop);
      else if (bus.rx_drop) drop_extra++;
    end
    chk("nak_hold", bad, 0);
    chk("nak_drop", drop_seen, 1);
    chk("nak_drop_extra", drop_extra, 0);
    sync();
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    sync();
    @(negedge clk_in);
    chk("nak_done", {bus.tx_valid, bus.bus_req}, 2'b00);
    sync();

    // reset in the middle of a burst
    send_byte(8'h44); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h00);
    wait_tx(got, a, d, req);
    wait_tx(got, a, d, req);
    bad = 0;
    @(negedge clk_in);
    while (!bus.ram_oe && bad < 20) begin
      @(negedge clk_in);
      bad++;
    end
    chk("mid_oe", bus.ram_oe, 1);
    reset_in = 1'b1;
    #1;
    chk_quiet("mid_rst");
    sync();
    reset_in = 1'b0;
    sync();
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    wait_reply("post_rst", 16'h1234, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
